// File: rtl/ht_cmd_initiator_pkg.sv
// Shared types for the hash-table task/result protocol and the command initiator.
package ht_cmd_initiator_pkg;

  localparam int HT_OPCODE_W = 3;
  localparam int HT_KEY_W    = 16;
  localparam int HT_VALUE_W  = 16;
  localparam int HT_TAG_W    = 8;

  typedef enum logic [HT_OPCODE_W-1:0] {
    OP_SEARCH  = 3'd0,
    OP_INSERT  = 3'd1,
    OP_DELETE  = 3'd2,
    OP_INSERT2 = 3'd3
  } ht_opcode_e;

  typedef struct packed {
    logic [HT_OPCODE_W-1:0] opcode;
    logic [HT_KEY_W-1:0]    key;
    logic [HT_VALUE_W-1:0]  value;
  } ht_pdata_t;

  typedef struct packed {
    logic [HT_OPCODE_W-1:0] status;
    logic [HT_VALUE_W-1:0]  value;
  } ht_result_t;

  typedef struct packed {
    logic [HT_TAG_W-1:0] tag;
    logic                local_err;
  } ht_init_tag_entry_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_CLEAR,
    ST_WAIT
  } ht_init_state_e;

  function automatic logic is_valid_opcode(input logic [HT_OPCODE_W-1:0] opcode);
    return opcode inside {OP_SEARCH, OP_INSERT, OP_DELETE, OP_INSERT2};
  endfunction

endpackage

// File: rtl/ht_cmd_initiator_if.sv
// Result channel from the hash-table core back to the initiator (valid/ready).
interface ht_res_if import ht_cmd_initiator_pkg::*; ();

  ht_result_t result;
  logic       valid;
  logic       ready;

  modport master (output result, output valid, input ready);
  modport slave  (input result, input valid, output ready);

endinterface

// File: rtl/ht_cmd_initiator_tag_fifo.sv
// Show-ahead synchronous FIFO holding {tag, local_err} for every accepted request.
module ht_tag_fifo import ht_cmd_initiator_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = HT_TAG_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full is judged before this cycle's pop, so a push at full is dropped even if a pop frees a slot.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ht_cmd_initiator.sv
// Issues tagged tasks to the hash table, returns results in request order, answers unknown
// opcodes locally, sequences the RAM clear handshake and flags a stalled table.
module ht_cmd_initiator import ht_cmd_initiator_pkg::*; #(
  parameter int TAG_WIDTH       = HT_TAG_W,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  ht_pdata_t            req_pdata_i,
  input  logic [TAG_WIDTH-1:0] req_tag_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output ht_pdata_t            pdata_out_o,
  output logic                 pdata_out_valid_o,
  input  logic                 pdata_out_ready_i,
  ht_res_if.slave              ht_res_in,
  output ht_result_t           rsp_result_o,
  output logic [TAG_WIDTH-1:0] rsp_tag_o,
  output logic                 rsp_err_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  input  logic                 clear_req_i,
  output logic                 clear_ram_run_o,
  input  logic                 clear_ram_done_i,
  output logic                 clear_done_o,
  output logic                 stall_o
);

  localparam int ENTRY_W = TAG_WIDTH + 1;
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  ht_init_state_e       state_q, state_d;
  logic                 clear_hold_q, clear_hold_d;
  ht_result_t           rsp_result_q, rsp_result_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 stall_q, stall_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               head_err, head_local;
  logic               req_known, clear_start, accept_en, slot_free, res_ready;

  ht_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ENTRY_W)
  ) u_tag_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i ({req_tag_i, ~req_known}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Request side: unknown opcodes are absorbed here and never reach the table.
  assign req_known         = is_valid_opcode(req_pdata_i.opcode);
  assign clear_start       = clear_req_i & ~clear_hold_q;
  assign accept_en         = ~rst_i & (state_q == ST_RUN) & ~clear_start & ~fifo_full;
  assign pdata_out_o       = req_pdata_i;
  assign pdata_out_valid_o = req_valid_i & accept_en & req_known;
  assign req_ready_o       = accept_en & (req_known ? pdata_out_ready_i : 1'b1);
  assign fifo_push         = req_valid_i & req_ready_o;

  // Response side: a table result is only taken when the FIFO head is waiting for one.
  assign head_err        = fifo_head[0];
  assign head_local      = ~fifo_empty & head_err;
  assign slot_free       = ~rsp_valid_q | rsp_ready_i;
  assign res_ready       = slot_free & ~fifo_empty & ~head_err;
  assign ht_res_in.ready = res_ready;
  assign fifo_pop        = slot_free & (head_local | (ht_res_in.valid & res_ready));

  always_comb begin
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q & ~rsp_ready_i;
    if (fifo_pop) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = head_local ? '0 : ht_res_in.result;
      rsp_tag_d    = fifo_head[ENTRY_W-1:1];
      rsp_err_d    = head_local;
    end
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    stall_d  = stall_q | (wd_cnt_q == WD_LIMIT);
    if (fifo_empty | fifo_pop) wd_cnt_d = '0;
    else if (wd_cnt_q != '1)   wd_cnt_d = wd_cnt_q + WD_W'(1);
  end

  // clear_hold keeps a still-high clear_req_i from re-arming the sequence right after it ends.
  always_comb begin
    state_d         = state_q;
    clear_hold_d    = clear_hold_q & clear_req_i;
    clear_ram_run_o = 1'b0;
    clear_done_o    = 1'b0;
    case (state_q)
      ST_RUN:   if (clear_start) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty & ~rsp_valid_q) state_d = ST_CLEAR;
      ST_CLEAR: begin
        clear_ram_run_o = 1'b1;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        if (clear_ram_done_i) begin
          clear_done_o = 1'b1;
          clear_hold_d = clear_req_i;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_RUN;
      clear_hold_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      wd_cnt_q     <= '0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_hold_q <= clear_hold_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      wd_cnt_q     <= wd_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign rsp_result_o = rsp_result_q;
  assign rsp_tag_o    = rsp_tag_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign stall_o      = stall_q;

endmodule

// File: tb/tb_ht_cmd_initiator.sv
// Directed scenarios plus randomized traffic against an in-order request/response model.
module tb_ht_cmd_initiator;
  import ht_cmd_initiator_pkg::*;

  typedef struct {
    logic [7:0] tag;
    logic       err;
    ht_result_t result;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  ht_pdata_t  req_pdata;
  logic [7:0] req_tag;
  logic       req_valid, req_ready;
  ht_pdata_t  pdata_out;
  logic       pdata_out_valid, pdata_out_ready;
  ht_result_t rsp_result;
  logic [7:0] rsp_tag;
  logic       rsp_err, rsp_valid, rsp_ready;
  logic       clear_req, clear_ram_run, clear_ram_done, clear_done, stall;

  ht_res_if res_if ();

  always #5 clk = ~clk;

  ht_cmd_initiator #(
    .TAG_WIDTH       (8),
    .MAX_OUTSTANDING (4),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_pdata_i       (req_pdata),
    .req_tag_i         (req_tag),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .pdata_out_o       (pdata_out),
    .pdata_out_valid_o (pdata_out_valid),
    .pdata_out_ready_i (pdata_out_ready),
    .ht_res_in         (res_if),
    .rsp_result_o      (rsp_result),
    .rsp_tag_o         (rsp_tag),
    .rsp_err_o         (rsp_err),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .clear_req_i       (clear_req),
    .clear_ram_run_o   (clear_ram_run),
    .clear_ram_done_i  (clear_ram_done),
    .clear_done_o      (clear_done),
    .stall_o           (stall)
  );

  int n_vec = 0;
  int n_miss = 0;
  int n_acc = 0, n_tasks = 0, n_run = 0, n_done = 0;
  int cyc = 0, run_cyc = 0, rsp_cyc = 0;
  bit last_req_fire = 0, last_res_fire = 0, prev_res_fire = 0;
  bit tbl_hold = 0, tbl_rand = 0;
  ht_result_t prev_res;
  exp_t       exp_q[$];
  ht_pdata_t  tbl_q[$];
  logic [7:0] log_tag[$];
  logic       log_err[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic known_op(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  // Table behaviour: answers every task, in order, with a value derived from the task.
  function automatic ht_result_t table_answer(input ht_pdata_t p);
    ht_result_t r;
    r.status = p.opcode;
    r.value  = p.key ^ p.value;
    return r;
  endfunction

  task automatic tick();
    logic rq, tf, rf, sf;
    exp_t e;
    @(negedge clk);
    rq = req_valid && req_ready;
    tf = pdata_out_valid && pdata_out_ready;
    rf = res_if.valid && res_if.ready;
    sf = rsp_valid && rsp_ready;
    if (prev_res_fire) begin
      chk("rsp_lat_valid", rsp_valid, 1'b1);
      chk("rsp_lat_result", rsp_result, prev_res);
    end
    if (req_valid) chk("tbl_handshake", tf, rq && known_op(req_pdata.opcode));
    if (tf) begin
      chk("task_known_op", known_op(pdata_out.opcode), 1'b1);
      chk("task_passthru", pdata_out, req_pdata);
      tbl_q.push_back(pdata_out);
      n_tasks++;
    end
    if (rq) begin
      e.tag    = req_tag;
      e.err    = !known_op(req_pdata.opcode);
      e.result = e.err ? '0 : table_answer(req_pdata);
      exp_q.push_back(e);
      n_acc++;
    end
    if (rf) void'(tbl_q.pop_front());
    if (sf) begin
      $display("rsp tag=%02h err=%0d result=%05h cycle=%0d", rsp_tag, rsp_err, rsp_result, cyc);
      chk("rsp_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_result", rsp_result, e.result);
      end
      log_tag.push_back(rsp_tag);
      log_err.push_back(rsp_err);
      rsp_cyc = cyc;
    end
    if (clear_ram_run) begin
      n_run++;
      run_cyc = cyc;
    end
    if (clear_done) n_done++;
    prev_res_fire = rf;
    prev_res      = res_if.result;
    last_req_fire = rq;
    last_res_fire = rf;
    @(posedge clk);
    #1;
    cyc++;
    if (!(res_if.valid && !rf)) begin
      res_if.valid = 1'b0;
      if (!tbl_hold && tbl_q.size() > 0 && (!tbl_rand || $urandom_range(0, 2) != 0)) begin
        res_if.valid  = 1'b1;
        res_if.result = table_answer(tbl_q[0]);
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] tag);
    int n = 0;
    req_pdata.opcode = op;
    req_pdata.key    = 16'($urandom);
    req_pdata.value  = 16'($urandom);
    req_tag          = tag;
    req_valid        = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_req_fire && n < 100);
    req_valid = 1'b0;
    chk("send_accept", last_req_fire, 1'b1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic reset_check(input string tag);
    $display("reset check %s", tag);
    chk({tag, "_req_ready"}, req_ready, 1'b0);
    chk({tag, "_pdata_valid"}, pdata_out_valid, 1'b0);
    chk({tag, "_res_ready"}, res_if.ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_fields"}, {rsp_result, rsp_tag, rsp_err}, '0);
    chk({tag, "_clear_run"}, clear_ram_run, 1'b0);
    chk({tag, "_clear_done"}, clear_done, 1'b0);
    chk({tag, "_stall"}, stall, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    res_if.valid = 1'b0;
    clear_req = 1'b0;
    clear_ram_done = 1'b0;
    tbl_hold = 1'b0;
    tbl_rand = 1'b0;
    pdata_out_ready = 1'b1;
    rsp_ready = 1'b1;
    exp_q.delete();
    tbl_q.delete();
    prev_res_fire = 0;
    last_req_fire = 0;
    last_res_fire = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rand_traffic(input int n_req, input int max_cyc);
    int acc0 = n_acc;
    int issued = 0;
    tbl_rand = 1'b1;
    for (int c = 0; c < max_cyc && ((n_acc - acc0) < n_req || exp_q.size() > 0); c++) begin
      if (req_valid && last_req_fire) req_valid = 1'b0;
      if (!req_valid && issued < n_req && $urandom_range(0, 3) != 0) begin
        req_pdata.opcode = ($urandom_range(0, 4) == 0) ? 3'(4 + $urandom_range(0, 3))
                                                       : 3'($urandom_range(0, 3));
        req_pdata.key    = 16'($urandom);
        req_pdata.value  = 16'($urandom);
        req_tag          = 8'($urandom);
        req_valid        = 1'b1;
        issued++;
      end
      pdata_out_ready = ($urandom_range(0, 3) != 0);
      rsp_ready       = ($urandom_range(0, 3) != 0);
      tick();
    end
    if (req_valid && last_req_fire) req_valid = 1'b0;
    tbl_rand = 1'b0;
    pdata_out_ready = 1'b1;
    rsp_ready = 1'b1;
  endtask

  initial begin
    int n, n0, acc0;
    req_pdata       = '0;
    req_pdata.opcode = OP_SEARCH;
    req_tag         = 8'h00;
    req_valid       = 1'b1;
    pdata_out_ready = 1'b1;
    rsp_ready       = 1'b1;
    clear_req       = 1'b0;
    clear_ram_done  = 1'b0;
    res_if.valid    = 1'b0;
    res_if.result   = '0;
    #12;
    reset_check("init");
    do_reset();

    // Two table tasks returned in order.
    log_tag.delete(); log_err.delete();
    tbl_hold = 1;
    send(OP_SEARCH, 8'h11);
    send(OP_INSERT, 8'h22);
    tbl_hold = 0;
    drain("t1_drain", 50);
    chk("t1_count", log_tag.size(), 2);
    if (log_tag.size() == 2) begin
      chk("t1_tag0", log_tag[0], 8'h11);
      chk("t1_tag1", log_tag[1], 8'h22);
    end

    // Unknown opcode answered locally between two table tasks.
    log_tag.delete(); log_err.delete();
    n0 = n_tasks;
    send(OP_INSERT, 8'h05);
    send(3'd7, 8'h06);
    send(OP_DELETE, 8'h07);
    drain("t2_drain", 50);
    chk("t2_tasks", n_tasks - n0, 2);
    if (log_tag.size() == 3) begin
      chk("t2_tags", {log_tag[0], log_tag[1], log_tag[2]}, 24'h050607);
      chk("t2_errs", {log_err[0], log_err[1], log_err[2]}, 3'b010);
    end else chk("t2_count", log_tag.size(), 3);

    // Four in flight fills the FIFO; one result frees a slot for the fifth.
    tbl_hold = 1;
    for (int i = 0; i < 4; i++) send(OP_SEARCH, 8'(8'h30 + i));
    req_pdata.opcode = OP_INSERT;
    req_tag   = 8'h34;
    req_valid = 1'b1;
    tick();
    tick();
    chk("t3_full_block", req_ready, 1'b0);
    tbl_hold = 0;
    tick();
    tbl_hold = 1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_res_fire && n < 20);
    chk("t3_release", last_res_fire, 1'b1);
    tick();
    chk("t3_5th_next", last_req_fire, 1'b1);
    req_valid = 1'b0;
    tbl_hold = 0;
    drain("t3_drain", 100);

    // Response backpressure: slot fills, table is held off, nothing lost.
    log_tag.delete(); log_err.delete();
    tbl_hold = 1;
    send(OP_SEARCH, 8'h41);
    send(OP_INSERT2, 8'h42);
    rsp_ready = 0;
    tbl_hold = 0;
    repeat (10) tick();
    chk("t4_res_ready_low", res_if.ready, 1'b0);
    chk("t4_rsp_held", rsp_valid, 1'b1);
    chk("t4_held_tag", rsp_tag, 8'h41);
    rsp_ready = 1;
    drain("t4_drain", 50);
    if (log_tag.size() == 2) chk("t4_order", {log_tag[0], log_tag[1]}, 16'h4142);
    else chk("t4_count", log_tag.size(), 2);

    // Clear sequence: drain, one run pulse, done pulse, back to RUN.
    tbl_hold = 1;
    send(OP_SEARCH, 8'h51);
    send(OP_DELETE, 8'h52);
    clear_req = 1;
    req_pdata.opcode = OP_SEARCH;
    req_tag = 8'h5f;
    req_valid = 1'b1;
    tick();
    chk("t5_blocked", req_ready, 1'b0);
    req_valid = 1'b0;
    n0 = n_run;
    n = n_done;
    tbl_hold = 0;
    drain("t5_drain", 50);
    for (int i = 0; i < 20 && n_run == n0; i++) tick();
    chk("t5_run_after_rsp", run_cyc > rsp_cyc, 1'b1);
    repeat (19) tick();
    clear_ram_done = 1;
    tick();
    clear_ram_done = 0;
    chk("t5_done_pulse", n_done - n, 1);
    repeat (5) tick();
    chk("t5_run_once", n_run - n0, 1);
    clear_req = 0;
    tick();
    send(OP_SEARCH, 8'h53);
    drain("t5_post_drain", 50);

    // Watchdog with a single unanswered task.
    do_reset();
    tbl_hold = 1;
    send(OP_DELETE, 8'h61);
    repeat (15) tick();
    chk("t6_stall_early", stall, 1'b0);
    tick();
    chk("t6_stall_set", stall, 1'b1);
    tbl_hold = 0;
    drain("t6_drain", 50);
    repeat (3) tick();
    chk("t6_stall_sticky", stall, 1'b1);

    // Reset in the middle of random traffic.
    rand_traffic(20, 30);
    #1;
    rst = 1'b1;
    req_pdata.opcode = OP_SEARCH;
    req_valid = 1'b1;
    pdata_out_ready = 1'b1;
    #1;
    reset_check("mid");
    do_reset();

    // Long randomized run.
    acc0 = n_acc;
    rand_traffic(250, 20000);
    chk("rand_accepted", n_acc - acc0, 250);
    chk("rand_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
